// File: rtl/firmware_rom_loader_pkg.sv
// firmware_rom_loader_pkg
// Shared geometry defaults and FSM state encoding for the firmware ROM loader.
package firmware_rom_loader_pkg;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int NUM_WORDS = 896;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/firmware_rom_byte_packer.sv
// firmware_rom_byte_packer
// Packs upstream bytes little-endian into one ROM word.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   clear          return byte index to lane 0 and zero the word
//   take           a byte transfers this cycle
//   byte_data      the byte being transferred
//   word           packed word (lane k = k-th transferred byte)
//   word_complete  high in the cycle the 4th byte transfers
module firmware_rom_byte_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              take,
  input  logic [7:0]        byte_data,
  output logic [DATA_W-1:0] word,
  output logic              word_complete
);

  logic [1:0]        idx_q;
  logic [DATA_W-1:0] word_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (take) begin
      word_q[{idx_q, 3'b000} +: 8] <= byte_data;
      idx_q                        <= idx_q + 2'd1;
    end
  end

  assign word          = word_q;
  assign word_complete = take && (idx_q == 2'd3);

endmodule

// File: rtl/firmware_rom_loader.sv
// firmware_rom_loader
// Streams bytes from an upstream source into an on-chip ROM, one word per
// single-cycle write, with a running checksum of the written words.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   start, start_addr, word_count load request (checked for range in IDLE)
//   abort                         cancel the load in progress
//   byte_valid, byte_data         upstream byte stream; byte_ready = accept
//   address, byteenable, chipselect, write, debugaccess, writedata, clken
//                                 ROM write port
//   busy, done, error, checksum   status
module firmware_rom_loader #(
  parameter int ADDR_W    = firmware_rom_loader_pkg::ADDR_W,
  parameter int DATA_W    = firmware_rom_loader_pkg::DATA_W,
  parameter int NUM_WORDS = firmware_rom_loader_pkg::NUM_WORDS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic              debugaccess,
  output logic [DATA_W-1:0] writedata,
  output logic              clken,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);
  import firmware_rom_loader_pkg::*;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [DATA_W-1:0] checksum_q;
  logic              error_q;
  logic [DATA_W-1:0] word;
  logic              word_complete;
  logic              take;
  logic [ADDR_W:0]   range_end;
  logic              req_ok;

  // One extra bit so start_addr + word_count cannot wrap back into range.
  assign range_end = {1'b0, start_addr} + {1'b0, word_count};
  assign req_ok    = (word_count != '0) && (range_end <= (ADDR_W+1)'(NUM_WORDS));

  // An abort in the same cycle as a byte wins; the byte is not consumed.
  assign take = (state_q == ST_COLLECT) && byte_valid && !abort;

  firmware_rom_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (state_q == ST_IDLE),
    .take          (take),
    .byte_data     (byte_data),
    .word          (word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_ready  = 1'b0;
    chipselect  = 1'b0;
    write       = 1'b0;
    debugaccess = 1'b0;
    byteenable  = 4'h0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start && req_ok) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        byte_ready = 1'b1;
        if (abort)              state_d = ST_IDLE;
        else if (word_complete) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        chipselect  = 1'b1;
        write       = 1'b1;
        debugaccess = 1'b1;
        byteenable  = 4'hF;
        if (abort)                             state_d = ST_IDLE;
        else if (remaining_q == ADDR_W'(1))    state_d = ST_DONE;
        else                                   state_d = ST_COLLECT;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: the write in progress always completes, even when aborted,
  // so the checksum reflects every word actually written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      checksum_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        if (req_ok) begin
          addr_q      <= start_addr;
          remaining_q <= word_count;
          checksum_q  <= '0;
          error_q     <= 1'b0;
        end else begin
          error_q <= 1'b1;
        end
      end else if (state_q == ST_WRITE) begin
        checksum_q  <= checksum_q + word;
        addr_q      <= addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - ADDR_W'(1);
      end
    end
  end

  assign address   = addr_q;
  assign writedata = word;
  assign checksum  = checksum_q;
  assign error     = error_q;
  assign clken     = 1'b1;

endmodule

// File: tb/tb_firmware_rom_loader.sv
module tb_firmware_rom_loader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NW = 896;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] word_count;
  logic          abort;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect;
  logic          write;
  logic          debugaccess;
  logic [DW-1:0] writedata;
  logic          clken;
  logic          busy;
  logic          done;
  logic          error;
  logic [DW-1:0] checksum;

  firmware_rom_loader #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .word_count(word_count), .abort(abort), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .address(address),
    .byteenable(byteenable), .chipselect(chipselect), .write(write),
    .debugaccess(debugaccess), .writedata(writedata), .clken(clken),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  int done_cnt;
  int bad_strobe;

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] n;
    int            mode;   // 0: bytes 1,2,3..  1: all FF  2: random
    bit            rv;     // randomly toggle byte_valid
    bit            ms;     // pulse start mid-load
    bit            err;    // request expected to be rejected
    bit            ck_fixed;
    logic [DW-1:0] ck;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Observe the ROM port once per cycle (called at negedge).
  task automatic sample();
    if (write) begin
      wa.push_back(address);
      wd.push_back(writedata);
      if (chipselect !== 1'b1 || debugaccess !== 1'b1 || byteenable !== 4'hF) bad_strobe++;
    end else if (chipselect !== 1'b0 || debugaccess !== 1'b0) begin
      bad_strobe++;
    end
    if (done) done_cnt++;
  endtask

  task automatic clear_obs();
    wa.delete();
    wd.delete();
    done_cnt   = 0;
    bad_strobe = 0;
  endtask

  task automatic run_load(input vec_t v);
    logic [7:0]    bytes[$];
    logic [DW-1:0] exp_word;
    logic [DW-1:0] exp_sum;
    int            total;
    int            idx;
    int            cyc;
    int            budget;
    bit            busy_seen;
    bit            model_err;

    clear_obs();
    model_err = (v.n == 0) || (int'(v.a) + int'(v.n) > NW);
    check("model_err_agrees", {63'd0, model_err}, {63'd0, v.err});
    total = v.err ? 0 : int'(v.n) * 4;
    for (int k = 0; k < total; k++) begin
      if (v.mode == 0)      bytes.push_back(8'(k + 1));
      else if (v.mode == 1) bytes.push_back(8'hFF);
      else                  bytes.push_back(8'($urandom));
    end

    start_addr = v.a;
    word_count = v.n;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;

    if (v.err) begin
      busy_seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
        sample();
        if (busy) busy_seen = 1'b1;
        @(negedge clk);
      end
      check($sformatf("err_flag a=%0d n=%0d", v.a, v.n), {63'd0, error}, 64'd1);
      check("err_busy_seen", {63'd0, busy_seen}, 64'd0);
      check("err_writes", 64'(wa.size()), 64'd0);
      return;
    end

    check("start_clears_error", {63'd0, error}, 64'd0);
    idx    = 0;
    cyc    = 0;
    budget = total * 6 + 60;
    while (cyc < budget) begin
      sample();
      if (done_cnt != 0) break;
      if (v.ms && cyc == 7) begin
        start      = 1'b1;
        start_addr = '0;
        word_count = '0;
      end else begin
        start = 1'b0;
      end
      if (idx < total) begin
        byte_valid = v.rv ? 1'($urandom_range(0, 1)) : 1'b1;
        byte_data  = bytes[idx];
      end else begin
        byte_valid = 1'b0;
      end
      if (byte_ready && byte_valid) idx++;
      @(negedge clk);
      cyc++;
    end
    start      = 1'b0;
    byte_valid = 1'b0;
    check("done_seen", 64'(done_cnt), 64'd1);
    if (!v.rv) check("throughput_cycles", 64'(cyc), 64'(5 * int'(v.n)));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      sample();
    end
    check("single_done", 64'(done_cnt), 64'd1);
    check("idle_after_done", {63'd0, busy}, 64'd0);

    check("write_count", 64'(wa.size()), 64'(v.n));
    exp_sum = '0;
    for (int k = 0; k < int'(v.n); k++) begin
      exp_word = {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]};
      exp_sum  = exp_sum + exp_word;
      if (k < wa.size()) begin
        check($sformatf("addr[%0d]", k), 64'(wa[k]), 64'(int'(v.a) + k));
        check($sformatf("data[%0d]", k), 64'(wd[k]), 64'(exp_word));
      end
    end
    check("checksum", 64'(checksum), 64'(exp_sum));
    if (v.ck_fixed) check("checksum_const", 64'(checksum), 64'(v.ck));
    check("error_after_load", {63'd0, error}, 64'd0);
    check("strobes", 64'(bad_strobe), 64'd0);
  endtask

  initial begin
    vec_t va;
    int   cyc;

    reset_n    = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    abort      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;

    vecs[0] = '{a:10'd0,    n:10'd2,  mode:0, rv:0, ms:0, err:0, ck_fixed:1, ck:32'h0C0A0806};
    vecs[1] = '{a:10'd894,  n:10'd3,  mode:0, rv:0, ms:0, err:1, ck_fixed:0, ck:32'h0};
    vecs[2] = '{a:10'd895,  n:10'd1,  mode:1, rv:0, ms:0, err:0, ck_fixed:1, ck:32'hFFFFFFFF};
    vecs[3] = '{a:10'd0,    n:10'd0,  mode:0, rv:0, ms:0, err:1, ck_fixed:0, ck:32'h0};
    vecs[4] = '{a:10'd1000, n:10'd30, mode:0, rv:0, ms:0, err:1, ck_fixed:0, ck:32'h0};
    vecs[5] = '{a:10'd10,   n:10'd3,  mode:2, rv:1, ms:1, err:0, ck_fixed:0, ck:32'h0};
    vecs[6] = '{a:10'd890,  n:10'd6,  mode:2, rv:0, ms:0, err:0, ck_fixed:0, ck:32'h0};
    vecs[7] = '{a:10'd890,  n:10'd7,  mode:0, rv:0, ms:0, err:1, ck_fixed:0, ck:32'h0};

    #12;
    check("rst_ctrl", {58'd0, byte_ready, chipselect, write, debugaccess, busy, done},
          64'd0);
    check("rst_err_be", {59'd0, error, byteenable}, 64'd0);
    check("rst_data", {22'd0, address, writedata}, 64'd0);
    check("rst_checksum", 64'(checksum), 64'd0);
    check("clken", {63'd0, clken}, 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_load(vecs[i]);

    // Abort after two bytes of word 0; error is still set from the last vector.
    clear_obs();
    start_addr = 10'd0; word_count = 10'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_start_clears_error", {63'd0, error}, 64'd0);
    byte_valid = 1'b1; byte_data = 8'hA5;
    @(negedge clk);
    byte_data = 8'h5A;
    @(negedge clk);
    byte_valid = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int c = 0; c < 6; c++) begin
      sample();
      @(negedge clk);
    end
    check("abort_collect_writes", 64'(wa.size()), 64'd0);
    check("abort_collect_done", 64'(done_cnt), 64'd0);
    check("abort_collect_idle", {62'd0, busy, byte_ready}, 64'd0);
    va = '{a:10'd5, n:10'd2, mode:2, rv:0, ms:0, err:0, ck_fixed:0, ck:32'h0};
    run_load(va);

    // Abort during the WRITE cycle: that write stands, no done pulse.
    clear_obs();
    start_addr = 10'd20; word_count = 10'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h11;
    cyc = 0;
    while (wa.size() == 0 && cyc < 30) begin
      sample();
      if (wa.size() == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("abort_write_reached", 64'(wa.size()), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sample();
      @(negedge clk);
    end
    byte_valid = 1'b0;
    check("abort_write_count", 64'(wa.size()), 64'd1);
    check("abort_write_done", 64'(done_cnt), 64'd0);
    check("abort_write_busy", {63'd0, busy}, 64'd0);
    check("abort_write_checksum", 64'(checksum), 64'h11111111);

    // Reset asserted in the WRITE cycle of word 1 of a 4-word load.
    clear_obs();
    start_addr = 10'd100; word_count = 10'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h3C;
    cyc = 0;
    while (wa.size() < 2 && cyc < 40) begin
      sample();
      if (wa.size() < 2) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("rst_mid_reached", 64'(wa.size()), 64'd2);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {58'd0, byte_ready, chipselect, write, debugaccess, busy, done},
          64'd0);
    check("rst_mid_err_be", {59'd0, error, byteenable}, 64'd0);
    check("rst_mid_data", {22'd0, address, writedata}, 64'd0);
    check("rst_mid_checksum", 64'(checksum), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      sample();
    end
    byte_valid = 1'b0;
    check("rst_mid_no_writes", 64'(wa.size()), 64'd2);
    check("rst_mid_idle", {62'd0, busy, done_cnt != 0}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/firmware_rom_loader.md
FIRMWARE_ROM_LOADER -- requirements
Module: firmware_rom_loader

Interface
REQ-001 SHALL have parameters: ADDR_W, default 10, word-address width; DATA_W, default 32, ROM word width; NUM_WORDS, default 896, ROM depth in words.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load.
- start_addr  in  ADDR_W  first word address of the load.
- word_count  in  ADDR_W  number of words to load.
- abort  in  1  cancel the load in progress.
- byte_valid  in  1  upstream byte available.
- byte_data  in  8  upstream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- address  out  ADDR_W  ROM word address.
- byteenable  out  4  ROM byte lanes.
- chipselect  out  1  ROM select.
- write  out  1  ROM write strobe.
- debugaccess  out  1  ROM write enable qualifier.
- writedata  out  DATA_W  ROM write word.
- clken  out  1  ROM clock enable.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky load-request error.
- checksum  out  DATA_W  sum of written words.

Function
REQ-003 SHALL implement a four-state FSM: IDLE, COLLECT, WRITE, DONE.
REQ-004 In IDLE, start with word_count in 1..NUM_WORDS and start_addr+word_count <= NUM_WORDS SHALL latch both values, clear checksum and error, and go to COLLECT next cycle.
REQ-005 In IDLE, start with word_count=0 or start_addr+word_count > NUM_WORDS SHALL set error and remain in IDLE; no ROM access SHALL occur.
REQ-006 Address-range arithmetic SHALL use ADDR_W+1 bits so the sum cannot wrap.
REQ-007 start SHALL be ignored outside IDLE, with no effect on error.
REQ-008 byte_ready SHALL be 1 only in COLLECT; a byte transfers when byte_valid and byte_ready are both 1.
REQ-009 Bytes SHALL pack little-endian: transferred byte k (0..3) goes to writedata[8k+7:8k].
REQ-010 The 4th transferred byte SHALL move the FSM to WRITE on the next cycle.
REQ-011 WRITE SHALL last exactly one cycle, driving chipselect=write=debugaccess=1, byteenable=4'hF, address=current word address and writedata=packed word.
REQ-012 In every state other than WRITE, chipselect, write and debugaccess SHALL be 0.
REQ-013 On leaving WRITE the block SHALL add writedata to checksum modulo 2^DATA_W, increment the address and decrement the remaining count.
REQ-014 From WRITE, a remaining count of 0 after the decrement SHALL go to DONE; otherwise it SHALL go to COLLECT.
REQ-015 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-016 busy SHALL be 1 in COLLECT, WRITE and DONE.
REQ-017 abort in COLLECT SHALL discard the partial word and go to IDLE with no write and no done pulse.
REQ-018 abort in WRITE SHALL let that cycle's write complete, then go to IDLE without a done pulse.
REQ-019 abort in IDLE or DONE SHALL have no effect.
REQ-020 clken SHALL be constant 1.
REQ-021 Maximum throughput SHALL be one word per 5 cycles when byte_valid is held at 1.

Reset
REQ-022 reset_n=0 SHALL immediately force state IDLE and set byte_ready, chipselect, write, debugaccess, busy, done and error to 0.
REQ-023 reset_n=0 SHALL immediately set address, byteenable, writedata and checksum to 0.
REQ-024 Reset asserted mid-load SHALL abandon the load with no further ROM write.

Structure
REQ-025 Package firmware_rom_loader_pkg SHALL hold ADDR_W, DATA_W, NUM_WORDS and the FSM state encoding.
REQ-026 Byte packing and the byte index counter SHALL be a sub-module, firmware_rom_byte_packer, with a word-complete output and a clear input.

Verification
REQ-027 Bench SHALL cover: start_addr=0, word_count=2, bytes 01 02 03 04 05 06 07 08 -> writes 0x04030201 @0 and 0x08070605 @1, checksum=0x0C0A0806, one done pulse.
REQ-028 Bench SHALL cover: start_addr=894, word_count=3 -> error=1, no write, busy stays 0.
REQ-029 Bench SHALL cover: start_addr=895, word_count=1, bytes FF FF FF FF -> one write @895 of 0xFFFFFFFF, done pulse.
REQ-030 Bench SHALL cover: abort after 2 bytes of word 0 -> no write, no done, back to IDLE; next valid start succeeds and clears error.
REQ-031 Bench SHALL cover: byte_valid toggling randomly during a 3-word load -> correct words, address increments 10,11,12, and start pulsed mid-load is ignored.
REQ-032 Bench SHALL cover: reset_n low in the WRITE cycle of word 1 of 4 -> all outputs 0 and no further writes.
